// File: rtl/sram_frame_reader_pkg.sv
// Shared SRAM port types and frame reader state for the VGA read path.
// Optional build macro SRAM_READER_WRAP_EN selects continuous frame scanning.
package sram_frame_reader_pkg;

  localparam int SRAM_ADDRESS_WIDTH = 18;
  localparam int SRAM_DATA_WIDTH    = 16;

  typedef logic [SRAM_ADDRESS_WIDTH-1:0] SramAddress_t;
  typedef logic [SRAM_DATA_WIDTH-1:0]    SramData_t;

  typedef struct packed {
    SramAddress_t address;
    SramData_t    dout;
    logic         we_n;
    logic         oe_n;
    logic         den;
  } SramRequest_t;

  typedef struct packed {
    SramData_t din;
    logic      done;
  } SramResult_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } SramReaderState_t;

endpackage

// File: rtl/sram_read_fifo.sv
// Prefetch FIFO for the frame reader: single-cycle flush, unreset storage.
// Caller must never push while full.
module sram_read_fifo
  import sram_frame_reader_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  SramData_t     din,
  output SramData_t     head,
  output logic [CW-1:0] count
);

  SramData_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sram_frame_reader.sv
// VGA-slot SRAM read engine streaming one frame into a prefetch FIFO.
// Define SRAM_READER_WRAP_EN for continuous scanning instead of stopping.
module sram_frame_reader
  import sram_frame_reader_pkg::*;
#(
  parameter int           FIFO_DEPTH  = 8,
  parameter SramAddress_t BASE_ADDR   = '0,
  parameter int           FRAME_WORDS = 38400,
  localparam int CW  = $clog2(FIFO_DEPTH) + 1,
  localparam int WCW = $clog2(FRAME_WORDS + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_start,
  output SramRequest_t request,
  input  SramResult_t  result,
  input  logic         pop,
  output SramData_t    data,
  output logic         valid,
  output logic         underflow
);

  SramReaderState_t state;
  SramAddress_t     addr;
  logic [WCW-1:0]   wcount;
  logic [CW-1:0]    fcount;
  SramData_t        head;
  logic             issuing;
  logic             accept;
  logic             last;

  assign issuing = (state == FETCH) && (fcount < CW'(FIFO_DEPTH));
  assign accept  = issuing && result.done && !frame_start;
  assign last    = (wcount == WCW'(FRAME_WORDS - 1));
  assign valid   = (fcount != '0);
  assign data    = valid ? head : '0;

  // Request depends only on registered state, never on result.
  assign request.address = addr;
  assign request.dout    = '0;
  assign request.we_n    = 1'b1;
  assign request.oe_n    = !issuing;
  assign request.den     = 1'b0;

  sram_read_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (frame_start),
    .push  (accept),
    .pop   (pop && !frame_start),
    .din   (result.din),
    .head  (head),
    .count (fcount)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= BASE_ADDR;
      wcount    <= '0;
      underflow <= 1'b0;
    end else if (frame_start) begin
      state     <= FETCH;
      addr      <= BASE_ADDR;
      wcount    <= '0;
      underflow <= 1'b0;
    end else begin
      if (pop && !valid)
        underflow <= 1'b1;
      if (accept) begin
        addr   <= addr + 1'b1;
        wcount <= wcount + 1'b1;
        if (last) begin
`ifdef SRAM_READER_WRAP_EN
          addr   <= BASE_ADDR;
          wcount <= '0;
`else
          state  <= DONE;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_frame_reader.sv
// Randomized/directed bench for sram_frame_reader against a queue model.
// Model follows SRAM_READER_WRAP_EN the same way the design build does.
module tb_sram_frame_reader;
  import sram_frame_reader_pkg::*;

  localparam int           D    = 8;
  localparam SramAddress_t BASE = 18'h3FFFA;
  localparam int           FW   = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         frame_start;
  logic         pop;
  SramRequest_t request;
  SramResult_t  result;
  SramData_t    data;
  logic         valid;
  logic         underflow;

  sram_frame_reader #(
    .FIFO_DEPTH  (D),
    .BASE_ADDR   (BASE),
    .FRAME_WORDS (FW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .request     (request),
    .result      (result),
    .pop         (pop),
    .data        (data),
    .valid       (valid),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  logic [15:0]  q[$];
  logic [17:0]  maddr;
  int           mcnt;
  bit           fetching;
  bit           mund;
  int           n_assert = 0;
  int           n_fail = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    maddr    = BASE;
    mcnt     = 0;
    fetching = 0;
    mund     = 0;
  endtask

  task automatic check_all(string tag);
    logic [15:0] exp_data;
    exp_data = (q.size() != 0) ? q[0] : 16'h0;
    chk({tag, ".valid"}, 32'(valid), 32'(q.size() != 0));
    chk({tag, ".data"}, 32'(data), 32'(exp_data));
    chk({tag, ".underflow"}, 32'(underflow), 32'(mund));
    chk({tag, ".address"}, 32'(request.address), 32'(maddr));
    chk({tag, ".oe_n"}, 32'(request.oe_n),
        32'(!(fetching && q.size() < D)));
    chk({tag, ".we_n"}, 32'(request.we_n), 32'd1);
    chk({tag, ".den"}, 32'(request.den), 32'd0);
    chk({tag, ".dout"}, 32'(request.dout), 32'd0);
  endtask

  task automatic step(string tag, bit fs, bit p, bit d);
    bit iss;
    frame_start = fs;
    pop         = p;
    result.done = d;
    result.din  = maddr[15:0];
    if (fs) begin
      q.delete();
      maddr    = BASE;
      mcnt     = 0;
      mund     = 0;
      fetching = 1;
    end else begin
      iss = fetching && (q.size() < D);
      if (p) begin
        if (q.size() != 0) void'(q.pop_front());
        else mund = 1;
      end
      if (iss && d) begin
        q.push_back(maddr[15:0]);
        maddr = maddr + 18'd1;
        mcnt++;
        if (mcnt == FW) begin
`ifdef SRAM_READER_WRAP_EN
          maddr = BASE;
          mcnt  = 0;
`else
          fetching = 0;
`endif
        end
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  bit tog;

  initial begin
    rst         = 1'b1;
    frame_start = 1'b0;
    pop         = 1'b0;
    result      = '0;
    model_reset();
    #3;
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("post_reset");

    // pop held high: streams the frame, address wraps past 3FFFF
    step("stream_fs", 1, 1, 0);
    tog = 0;
    for (int i = 0; i < 40; i++) begin
      tog = ~tog;
      step("stream", 0, 1, tog);
    end

    // pop idle: FIFO fills, then one pop frees a slot
    step("fill_fs", 1, 0, 0);
    tog = 0;
    for (int i = 0; i < 20; i++) begin
      tog = ~tog;
      step("fill", 0, 0, tog);
    end
    step("fill_pop", 0, 1, 0);
    step("fill_next", 0, 0, 1);
    for (int i = 0; i < 30; i++)
      step("drain", 0, 1, 1);

    // underflow is sticky until frame_start
    step("uf_pop", 0, 1, 0);
    step("uf_hold", 0, 0, 0);
    step("uf_clear", 1, 0, 0);

    // frame_start during a done with 3 words buffered
    tog = 0;
    for (int i = 0; i < 6; i++) begin
      tog = ~tog;
      step("pre_fs", 0, 0, tog);
    end
    step("fs_on_done", 1, 1, 1);
    step("after_fs", 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 39) == 0), 1'($urandom),
           1'($urandom));

    // asynchronous reset mid-frame
    step("mid_fs", 1, 0, 0);
    for (int i = 0; i < 5; i++)
      step("mid", 0, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("rst_release");
    step("restart", 1, 0, 0);
    step("restart1", 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
